// File: rtl/comparador_serial.sv
// Bit-serial MSB-first magnitude comparator with signed/unsigned mode and start/done handshake.
// Define COMPARADOR_EARLY_EXIT_EN to stop scanning at the first differing bit.
module comparador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             igual,
  output logic             maior,
  output logic             menor
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, b_r;
  logic             sgn_r;
  logic [IW-1:0]    idx;
  logic             found_r, gt_r;
  logic             cur_diff, cur_gt, at_msb, at_lsb;
  logic             load, finish;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // The sign bit inverts the ordering: in two's complement a 1 there means negative.
  always_comb begin
    at_msb     = (idx == IW'(WIDTH-1));
    at_lsb     = (idx == '0);
    cur_diff   = a_r[idx] ^ b_r[idx];
    cur_gt     = (at_msb && sgn_r) ? b_r[idx] : a_r[idx];
    state_next = state;
    load       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
`ifdef COMPARADOR_EARLY_EXIT_EN
        finish = at_lsb || cur_diff;
`else
        finish = at_lsb;
`endif
        if (finish) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SCAN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  // Only the first (most significant) difference is recorded; results change only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sgn_r   <= 1'b0;
      idx     <= '0;
      found_r <= 1'b0;
      gt_r    <= 1'b0;
      igual   <= 1'b0;
      maior   <= 1'b0;
      menor   <= 1'b0;
    end else begin
      if (load) begin
        a_r     <= A;
        b_r     <= B;
        sgn_r   <= signed_mode;
        idx     <= IW'(WIDTH-1);
        found_r <= 1'b0;
        gt_r    <= 1'b0;
      end else if (state == SCAN) begin
        if (cur_diff && !found_r) begin
          found_r <= 1'b1;
          gt_r    <= cur_gt;
        end
        if (!at_lsb) idx <= idx - 1'b1;
      end
      if (finish) begin
        igual <= !(found_r || cur_diff);
        maior <= found_r ? gt_r  : (cur_diff && cur_gt);
        menor <= found_r ? !gt_r : (cur_diff && !cur_gt);
      end
    end
  end

endmodule

// File: tb/tb_comparador_serial.sv
// Scoreboard bench for comparador_serial (WIDTH=8); expected latency follows COMPARADOR_EARLY_EXIT_EN.
module tb_comparador_serial;

  localparam int WIDTH = 8;
  localparam int LIMIT = 2*WIDTH + 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             busy, done, igual, maior, menor;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] res;
    int         lat;
  } exp_t;

  exp_t exp_q[$];

  comparador_serial #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .A(A), .B(B), .busy(busy), .done(done),
    .igual(igual), .maior(maior), .menor(menor)
  );

  always #5 clk = ~clk;

  // Reference: {igual, maior, menor} from native arithmetic comparison.
  function automatic logic [2:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic s);
    if (a == b) return 3'b100;
    if (s) return ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
    return (a > b) ? 3'b010 : 3'b001;
  endfunction

  // Cycles from the start edge to the done cycle.
  function automatic int ref_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    int p;
    x = a ^ b;
    p = -1;
    for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
`ifdef COMPARADOR_EARLY_EXIT_EN
    if (p >= 0) return 1 + WIDTH - p;
`endif
    return WIDTH + 1;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after the start edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    exp_t e;
    A = a; B = b; signed_mode = s; start = 1'b1;
    e.res = ref_result(a, b, s);
    e.lat = ref_latency(a, b);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat, output bit ok);
    lat = c0;
    ok  = 1'b0;
    while (!ok && lat <= LIMIT) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, igual, maior, menor} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %b expected 00000", {busy, done, igual, maior, menor});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic s, input string name);
    int lat;
    bit ok;
    exp_t e;
    applyStimulus(a, b, s);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s busy_rise: got %b expected 1", name, busy);
    end
    wait_done(1, lat, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s timeout: no done within %0d cycles, expected %0d", name, LIMIT, e.lat);
    end else if ({igual, maior, menor} !== e.res || lat != e.lat || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s result: got res=%b lat=%0d busy=%b expected res=%b lat=%0d busy=0",
               name, {igual, maior, menor}, lat, busy, e.res, e.lat);
    end
    @(negedge clk);
    vectors++;
    if ({done, igual, maior, menor} !== {1'b0, e.res}) begin
      miscompares++;
      $display("[TB] FAIL %s hold: got done/res=%b expected %b", name, {done, igual, maior, menor},
               {1'b0, e.res});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    bit ok;
    exp_t e;
    applyStimulus(8'h12, 8'h13, 1'b0);
    wait_done(1, lat, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || {igual, maior, menor} !== e.res || lat != e.lat) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got ok=%0d res=%b lat=%0d expected res=%b lat=%0d",
               ok, {igual, maior, menor}, lat, e.res, e.lat);
    end
    applyStimulus(8'hFF, 8'h00, 1'b0);
    vectors++;
    if ({busy, igual, maior, menor} !== 4'b1001) begin
      miscompares++;
      $display("[TB] FAIL b2b_nogap: got busy/res=%b expected 1001", {busy, igual, maior, menor});
    end
    wait_done(1, lat, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || {igual, maior, menor} !== e.res || lat != e.lat) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got ok=%0d res=%b lat=%0d expected res=%b lat=%0d",
               ok, {igual, maior, menor}, lat, e.res, e.lat);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat, pulses;
    exp_t e;
    logic [2:0] res;
    pulses = 0;
    lat = 0;
    res = 3'b000;
    applyStimulus(8'h40, 8'h20, 1'b0);
    A = 8'h00; B = 8'hFF; start = 1'b1;
    for (int c = 1; c <= LIMIT; c++) begin
      if (done === 1'b1) begin
        if (pulses == 0) begin
          lat = c;
          res = {igual, maior, menor};
        end
        pulses++;
      end
      @(negedge clk);
      start = 1'b0;
      A = A + 8'h35; B = B ^ 8'h5A; signed_mode = ~signed_mode;
    end
    e = exp_q.pop_front();
    vectors++;
    if (pulses != 1 || res !== e.res || lat != e.lat) begin
      miscompares++;
      $display("[TB] FAIL ignore_start: got pulses=%0d res=%b lat=%0d expected pulses=1 res=%b lat=%0d",
               pulses, res, lat, e.res, e.lat);
    end
  endtask

  task automatic test_reset_midscan;
    int pulses;
    exp_t e;
    pulses = 0;
    applyStimulus(8'h01, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = exp_q.pop_front();
    vectors++;
    if ({busy, done, igual, maior, menor} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL midscan_reset: got %b expected 00000", {busy, done, igual, maior, menor});
    end
    for (int c = 0; c < LIMIT; c++) begin
      if (done === 1'b1 || busy === 1'b1) pulses++;
      @(negedge clk);
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL midscan_nodone: got %0d active cycles expected 0 (discarded res=%b)",
               pulses, e.res);
    end
    test_single(8'h03, 8'hF9, 1'b1, "after_reset");
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = WIDTH'($urandom);
      b = (i % 4 == 0) ? a : ((i % 4 == 1) ? (a ^ WIDTH'(1 << (i % WIDTH))) : WIDTH'($urandom));
      test_single(a, b, logic'(i % 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single(8'h5A, 8'h5A, 1'b0, "equal");
    test_single(8'h80, 8'h7F, 1'b0, "unsigned_msb");
    test_single(8'h80, 8'h7F, 1'b1, "signed_msb");
    test_single(8'h7F, 8'hFF, 1'b1, "signed_neg_one");
    test_single(8'h00, 8'h01, 1'b1, "lsb_only");
    test_back_to_back();
    test_ignore_start();
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
